top_vector_sequencer: RTL
=========================

Name: top_vector_sequencer

Overview:
- Hardware stimulus/check controller for the TOP datapath (inputs X, Y[7:0], Z[0:5]; outputs A[31:0], B, C).
- Holds a small vector memory of stimulus plus expected-response pairs.
- On start, drives TOP's inputs one vector at a time, waits a programmable settle interval, samples A/B/C, compares them against the expected values, and reports pass/fail, error count and first failing index.
- Replaces the fixed #1-stepped simulation sequences with a reusable on-chip sequencer.

Parameters:
- DEPTH, 16, number of vector entries; power of two.
- ADDR_W, 4, log2(DEPTH).
- STEP_CYCLES, 1, cycles each vector is held before sampling; must be ≥1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  vector memory write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_stim  in  15  stimulus word {X, Y[7:0], Z[0:5]}; X is bit 14.
- wr_exp  in  34  expected word {A[31:0], B, C}; A is bits 33:2.
- num_vectors  in  ADDR_W+1  vectors to run; sampled at start.
- start  in  1  begin run; one-cycle pulse or level.
- abort  in  1  terminate run.
- X  out  1  drive to TOP.X.
- Y  out  8  drive to TOP.Y.
- Z  out  6 [0:5]  drive to TOP.Z.
- A_in  in  32  from TOP.A.
- B_in  in  1  from TOP.B.
- C_in  in  1  from TOP.C.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run completion.
- pass  out  1  last completed run had zero mismatches.
- err_count  out  ADDR_W+1  mismatches in the last/current run.
- fail_idx  out  ADDR_W  index of first mismatching vector.
- fail_seen  out  1  at least one mismatch in the last/current run.

Behaviour:
- Reset values (synchronous, rst=1):
  - state=IDLE.
  - X=0, Y=0, Z=0.
  - busy=0, done=0, pass=0, err_count=0, fail_idx=0, fail_seen=0.
  - Vector memory is NOT cleared.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - wr_en writes mem[wr_addr] <= {wr_stim, wr_exp}.
  - start=1 at cycle T: latch n = min(num_vectors, DEPTH); clear err_count, fail_idx, fail_seen, pass; vec_idx=0.
  - If n==0, go to DONE; otherwise go to APPLY.
- APPLY:
  - Entered at T+1; X/Y/Z <= stimulus of mem[vec_idx], registered on entry; busy=1.
  - Stays STEP_CYCLES cycles, counted by a settle counter, then goes to SAMPLE.
- SAMPLE:
  - One cycle; X/Y/Z held.
  - Compare {A_in, B_in, C_in} against the expected word.
  - On mismatch: err_count++ (saturates at all-ones); if fail_seen==0, fail_idx <= vec_idx and fail_seen <= 1.
  - If vec_idx == n-1, go to DONE; else vec_idx++ and go to APPLY.
- DONE:
  - One cycle: done=1, pass <= (err_count==0 including this run's final compare), busy=0.
  - X/Y/Z return to 0 the next cycle; go to IDLE.
- Latency: done is asserted at cycle T + n*(STEP_CYCLES+1) + 1 for n>0, and at T+1 for n==0.
- Result registers hold until the next start or rst.
- start while busy: ignored.
- wr_en while busy: ignored; the memory is stable during a run.
- abort=1 in APPLY or SAMPLE:
  - Next state IDLE; X/Y/Z=0, busy=0.
  - done not pulsed, pass=0; err_count/fail_* keep partial values.
  - abort in IDLE or DONE: no effect.
- Simultaneous events and priority:
  - rst > abort > start.
  - abort and a final SAMPLE in the same cycle: abort wins, no done.
  - start in the DONE cycle is ignored; it must be re-issued in IDLE.
- rst mid-run: immediate return to reset values on the next edge; memory contents preserved.
- num_vectors > DEPTH is clamped to DEPTH; vec_idx never wraps past n-1.

Test Plan:
- Load 11 vectors with Y=i, Z=i, X=i[0]; expected = TOP golden values; num_vectors=11, STEP_CYCLES=1, start -> X/Y/Z step every 2 cycles, done at T+23, pass=1, err_count=0, fail_seen=0.
- Same load, but corrupt vector 4's expected A (flip bit 0) and vector 7's C -> done at T+23, pass=0, err_count=2, fail_idx=4, fail_seen=1.
- num_vectors=0, start -> done at T+1, pass=1, busy never high, X/Y/Z stay 0.
- num_vectors=20 with DEPTH=16 -> exactly 16 vectors applied, vec_idx stops at 15, done at T+33.
- Assert abort during vector 3's APPLY -> next cycle busy=0, X/Y/Z=0, no done pulse, pass=0; a subsequent start runs the full set normally.
- During a run, pulse wr_en to entry 0 and pulse start -> memory unchanged and the run is unaffected. Then assert rst mid-run -> all outputs go to reset values; rerun without reloading gives identical results.

Source files
------------

// File: rtl/top_vector_sequencer.sv
// On-chip stimulus/check sequencer for the TOP datapath: replays stored vectors,
// samples A/B/C after a settle interval and reports pass/fail statistics.
module top_vector_sequencer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [14:0]       wr_stim,
  input  logic [33:0]       wr_exp,
  input  logic [ADDR_W:0]   num_vectors,
  input  logic              start,
  input  logic              abort,
  output logic              X,
  output logic [7:0]        Y,
  output logic [0:5]        Z,
  input  logic [31:0]       A_in,
  input  logic              B_in,
  input  logic              C_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] fail_idx,
  output logic              fail_seen
);

  localparam int unsigned STIM_W = 15;
  localparam int unsigned EXP_W  = 34;
  localparam int unsigned MEM_W  = STIM_W + EXP_W;
  localparam int unsigned CNT_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned N_W    = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SAMPLE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] vec_idx_q, vec_idx_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [CNT_W-1:0]  settle_q, settle_d;
  logic              x_q, x_d;
  logic [7:0]        y_q, y_d;
  logic [5:0]        z_q, z_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_W-1:0]    err_q, err_d;
  logic [ADDR_W-1:0] fidx_q, fidx_d;
  logic              fseen_q, fseen_d;

  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic              mem_we_c;
  logic [MEM_W-1:0]  load_word_c;
  logic [EXP_W-1:0]  exp_word_c;
  logic              mismatch_c;
  logic              last_c;

  assign exp_word_c = mem_q[vec_idx_q][EXP_W-1:0];
  assign mismatch_c = ({A_in, B_in, C_in} != exp_word_c);
  assign last_c     = (N_W'(vec_idx_q) == n_q - N_W'(1));

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    vec_idx_d   = vec_idx_q;
    n_d         = n_q;
    settle_d    = settle_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_d       = err_q;
    fidx_d      = fidx_q;
    fseen_d     = fseen_q;
    mem_we_c    = 1'b0;
    load_word_c = mem_q[vec_idx_q];

    case (state_q)
      S_IDLE: begin
        mem_we_c = wr_en;
        if (start) begin
          n_d       = (num_vectors > N_W'(DEPTH)) ? N_W'(DEPTH) : num_vectors;
          err_d     = '0;
          fidx_d    = '0;
          fseen_d   = 1'b0;
          pass_d    = 1'b0;
          vec_idx_d = '0;
          if (n_d == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            load_word_c = mem_q[0];
            state_d     = S_APPLY;
            busy_d      = 1'b1;
            settle_d    = '0;
            {x_d, y_d, z_d} = load_word_c[MEM_W-1:EXP_W];
          end
        end
      end

      S_APPLY: begin
        if (abort) begin
          state_d = S_IDLE;
          {x_d, y_d, z_d} = '0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (settle_q == CNT_W'(STEP_CYCLES - 1)) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q + CNT_W'(1);
        end
      end

      S_SAMPLE: begin
        if (abort) begin
          state_d = S_IDLE;
          {x_d, y_d, z_d} = '0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          if (mismatch_c) begin
            if (err_q != '1) err_d = err_q + N_W'(1);
            if (!fseen_q) begin
              fidx_d  = vec_idx_q;
              fseen_d = 1'b1;
            end
          end
          if (last_c) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (err_d == '0);
          end else begin
            vec_idx_d   = vec_idx_q + ADDR_W'(1);
            load_word_c = mem_q[vec_idx_d];
            state_d     = S_APPLY;
            settle_d    = '0;
            {x_d, y_d, z_d} = load_word_c[MEM_W-1:EXP_W];
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        {x_d, y_d, z_d} = '0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      vec_idx_q <= '0;
      n_q       <= '0;
      settle_q  <= '0;
      x_q       <= 1'b0;
      y_q       <= '0;
      z_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      fidx_q    <= '0;
      fseen_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_idx_q <= vec_idx_d;
      n_q       <= n_d;
      settle_q  <= settle_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      fidx_q    <= fidx_d;
      fseen_q   <= fseen_d;
    end
  end

  // Vector memory survives reset; writes only land while idle
  always_ff @(posedge clk) begin
    if (!rst && mem_we_c) mem_q[wr_addr] <= {wr_stim, wr_exp};
  end

  assign X         = x_q;
  assign Y         = y_q;
  assign Z         = z_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_idx  = fidx_q;
  assign fail_seen = fseen_q;

endmodule
